// File: rtl/bcd2bin11.sv
// bcd2bin11: 4-digit BCD to 11-bit binary by reverse double-dabble, 12-cycle start->done, start ignored while busy/done.
// Define BCD2BIN_RANGE_CHECK_EN to build the digit-legality and >2047 residual check that drives err.
module bcd2bin11 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        busy,
  output logic        done,
  output logic [10:0] result,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] bcd_reg;
  logic [10:0] bin_reg;
  logic [15:0] bcd_sh;
  logic [15:0] bcd_nx;
  logic [10:0] bin_nx;
  logic        last_shift;

  assign busy       = (state == SHIFT);
  assign last_shift = (state == SHIFT) && (cnt == 4'd10);

  always_comb begin
    bcd_sh = {1'b0, bcd_reg[15:1]};
    bin_nx = {bcd_reg[0], bin_reg[10:1]};
    bcd_nx = bcd_sh;
    // A digit that received the upper digit's LSB holds 8+x; subtracting 3 restores 5+x.
    for (int i = 0; i < 4; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8)
        bcd_nx[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      bcd_reg <= 16'd0;
      bin_reg <= 11'd0;
      result  <= 11'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= {thousands, hundreds, tens, ones};
            bin_reg <= 11'd0;
            cnt     <= 4'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_nx;
          bin_reg <= bin_nx;
          cnt     <= cnt + 4'd1;
          if (last_shift) begin
            result <= bin_nx;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic bad_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_digit <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start)
        bad_digit <= (thousands > 4'd9) || (hundreds > 4'd9) ||
                     (tens > 4'd9) || (ones > 4'd9);
      // Anything left in the BCD register after 11 shifts is the part above 2047.
      if (last_shift)
        err <= bad_digit || (bcd_nx != 16'd0);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin11.sv
// Randomized and directed bench for bcd2bin11 against a decimal-arithmetic reference.
module tb_bcd2bin11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done, err;
  logic [10:0] result;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] held_result;
  logic        held_err;

  bcd2bin11 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the IDLE negedge after done.
  task automatic run_conv(input logic [3:0] th, input logic [3:0] hu,
                          input logic [3:0] te, input logic [3:0] on,
                          input int glitch_at);
    int   n;
    int   value;
    logic legal;
    logic exp_err;
    thousands = th; hundreds = hu; tens = te; ones = on;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    thousands = 4'($urandom); hundreds = 4'($urandom);
    tens = 4'($urandom); ones = 4'($urandom);
    check("busy_after_start", busy, 1);
    check("result_held_in_shift", result, held_result);
    while (!done && n < 30) begin
      start = (n == glitch_at);
      @(negedge clk);
      n++;
      if (n == 11) check("busy_last_shift", busy, 1);
    end
    start = 1'b0;
    check("done_latency", n, 12);
    check("busy_in_done", busy, 0);
    value = th * 1000 + hu * 100 + te * 10 + on;
    legal = (th <= 9) && (hu <= 9) && (te <= 9) && (on <= 9);
`ifdef BCD2BIN_RANGE_CHECK_EN
    exp_err = !legal || (value > 2047);
`else
    exp_err = 1'b0;
`endif
    if (legal) check("result", result, value % 2048);
    check("err", err, exp_err);
    held_result = result;
    held_err    = err;
    @(negedge clk);
    check("done_width", done, 0);
    check("result_hold", result, held_result);
    check("err_hold", err, held_err);
  endtask

  task automatic idle_window(input string tag);
    int pulses = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    held_result = 11'd0;
    held_err    = 1'b0;
    @(negedge clk);

    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 0);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 0);
    run_conv(4'd2, 4'd0, 4'd4, 4'd7, 0);
    run_conv(4'd2, 4'd0, 4'd4, 4'd8, 0);
    run_conv(4'd0, 4'd0, 4'd1, 4'hA, 0);
    run_conv(4'd0, 4'd0, 4'd0, 4'd9, 0);
    run_conv(4'd0, 4'd5, 4'd0, 4'd0, 3);
    idle_window("no_extra_done_after_ignored_start");

    // Reset during the sixth SHIFT cycle aborts the conversion.
    thousands = 4'd0; hundreds = 4'd7; tens = 4'd7; ones = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", err, 0);
    reset = 1'b0;
    held_result = 11'd0;
    held_err    = 1'b0;
    idle_window("no_done_after_abort");
    run_conv(4'd1, 4'd9, 4'd9, 4'd9, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] a, b, c, d;
      if ($urandom_range(0, 3) == 0) begin
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      end else begin
        a = 4'($urandom_range(0, 2)); b = 4'($urandom_range(0, 9));
        c = 4'($urandom_range(0, 9)); d = 4'($urandom_range(0, 9));
      end
      run_conv(a, b, c, d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
